// File: rtl/booth_decode_acc.sv
// ---------------------------------------------------------------------------
// booth_decode_acc : radix-8 Booth select decoder and partial-product accumulator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module booth_decode_acc #(
   parameter int MCAND_WIDTH = 8,
   parameter int DIGITS      = 3,
   parameter int SEL_WIDTH   = 7,
   parameter int PROD_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iStart,
   input  logic [MCAND_WIDTH-1:0] iMcand,
   input  logic                  iSelValid,
   input  logic [SEL_WIDTH-1:0]  iBoothSel,
   output logic                  oSelReady,
   output logic                  oBusy,
   output logic [PROD_WIDTH-1:0] oProd,
   output logic                  oValid,
   output logic                  oErr
);

   localparam int ACC_W = PROD_WIDTH + 3;
   localparam int CNT_W = $clog2(DIGITS + 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_ACC  = 2'd1;
   localparam logic [1:0] c_FIX  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]             r_state;
   logic [MCAND_WIDTH-1:0] r_mcand;
   logic [ACC_W-1:0]       r_acc;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_carry;
   logic                   r_err;
   logic [PROD_WIDTH-1:0]  r_prod;
   logic                   r_valid;

   logic [ACC_W-1:0]       w_a;
   logic [ACC_W-1:0]       w_a3;
   logic [ACC_W-1:0]       w_mag;
   logic                   w_neg;
   logic                   w_illegal;
   logic [ACC_W-1:0]       w_mult;
   logic [ACC_W-1:0]       w_term;
   logic [ACC_W-1:0]       w_carry_term;
   logic                   w_hs;

   assign w_a  = {{(ACC_W-MCAND_WIDTH){1'b0}}, r_mcand};
   assign w_a3 = w_a + (w_a << 1);

   // More than one hot bit: sel & (sel-1) keeps any bit beyond the lowest one.
   assign w_illegal = (iBoothSel & (iBoothSel - SEL_WIDTH'(1))) != '0;

   always_comb begin
      w_mag = '0;
      w_neg = 1'b0;
      case (iBoothSel)
         7'b0000001: w_mag = w_a;
         7'b0000010: w_mag = w_a << 1;
         7'b0000100: w_mag = w_a3;
         7'b0001000: w_mag = w_a << 2;
         7'b0010000: begin w_mag = w_a3;    w_neg = 1'b1; end
         7'b0100000: begin w_mag = w_a << 1; w_neg = 1'b1; end
         7'b1000000: begin w_mag = w_a;     w_neg = 1'b1; end
         default:    begin w_mag = '0;      w_neg = 1'b0; end
      endcase
   end

   assign w_mult       = w_neg ? (~w_mag + ACC_W'(1)) : w_mag;
   assign w_term       = w_mult << (3 * r_cnt);
   assign w_carry_term = r_carry ? (w_a << (3 * r_cnt)) : '0;
   assign w_hs         = iSelValid && (r_state == c_ACC);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
         r_prod  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (iStart) begin
                  r_state <= c_ACC;
                  r_mcand <= iMcand;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            c_ACC: begin
               if (w_hs) begin
                  r_acc   <= r_acc + w_term + w_carry_term;
                  r_carry <= w_neg;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  if (w_illegal) begin
                     r_err <= 1'b1;
                  end
                  if (r_cnt == CNT_W'(DIGITS - 1)) begin
                     r_state <= c_FIX;
                  end
               end
            end
            c_FIX: begin
               // Carry left over from a negative top digit lands above the last digit.
               if (r_carry) begin
                  r_acc <= r_acc + (w_a << (3 * DIGITS));
               end
               r_carry <= 1'b0;
               r_state <= c_DONE;
            end
            c_DONE: begin
               r_prod  <= r_acc[PROD_WIDTH-1:0];
               r_valid <= 1'b1;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign oSelReady = (r_state == c_ACC);
   assign oBusy     = (r_state != c_IDLE);
   assign oProd     = r_prod;
   assign oValid    = r_valid;
   assign oErr      = r_err;

endmodule

`default_nettype wire
